mtmp_blend: RTL and testbench
=============================

Name: mtmp_blend

Overview:
- Consumer of the mtmp weight stream in the over-exposure correction path.
- Aligns original and corrected pixels to the fixed-latency mtmp weight, then blends them:
  pix_out = (mtmp·corr + (1−mtmp)·orig), with mtmp in unsigned Q1.DW_DEC.
- Sits directly downstream of the mtmp weight generator. Streaming, no backpressure.
- Optional per-frame count of corrected pixels for firmware statistics.

Parameters:
- DW_IN, 10: pixel width.
- DW_DEC, 8: fractional bits of mtmp; mtmp width is DW_DEC+1.
- MTMP_LAT, 6: cycles from a pixel's in_vld to its mtmp arrival; must be ≥1.
- STAT_W, 22: statistics counter width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  pixel valid at input
- in_sof  input  1  first pixel of frame, qualified by in_vld
- pix_orig  input  DW_IN  original pixel
- pix_corr  input  DW_IN  corrected pixel
- mtmp  input  DW_DEC+1  blend weight; belongs to the pixel presented MTMP_LAT cycles earlier
- out_vld  output  1  blended pixel valid
- out_sof  output  1  frame start, aligned with out_vld
- pix_out  output  DW_IN  blended pixel
- stat_cnt  output  STAT_W  corrected-pixel count of the previous frame (MTMP_STAT_EN only)
- stat_vld  output  1  one-cycle pulse when stat_cnt updates (MTMP_STAT_EN only)

Behaviour:
- Single clock. Reset is asynchronous and active-low.
- Reset values: every register, including all outputs, clears to 0.
- Alignment:
  - in_vld, in_sof, pix_orig and pix_corr pass through a MTMP_LAT-deep delay line.
  - The line shifts every cycle, independent of valid. There is no enable.
- Stage B1 (delay-line output cycle):
  - w = (mtmp > 2^DW_DEC) ? 2^DW_DEC : mtmp.
  - Register pa = w·corr_d and pb = (2^DW_DEC − w)·orig_d. Each is DW_IN+DW_DEC+1 bits.
  - Register vld and sof alongside.
- Stage B2:
  - pix_out = (pa + pb + 2^(DW_DEC−1)) >> DW_DEC.
  - The result never exceeds 2^DW_IN − 1, so no saturation logic is needed.
- Latency: a pixel with in_vld at cycle t appears on out_vld at cycle t+MTMP_LAT+2.
- Bubbles:
  - Pipeline registers load every cycle.
  - pix_out is don't-care when out_vld=0, but it is deterministic (computed from delayed data).
- in_sof without in_vld is ignored: the sof path is ANDed with vld at the input.
- Reset mid-frame: all pipeline contents are discarded. The next out_vld appears no earlier than MTMP_LAT+2 cycles after the first post-reset in_vld.

Optional Feature:
- Macro MTMP_STAT_EN.
- Defined:
  - A counter increments on each out_vld pixel whose clamped weight w ≠ 0. w is carried with B1 into B2.
  - The counter saturates at 2^STAT_W − 1.
  - On out_vld & out_sof, stat_cnt ← counter and stat_vld pulses for 1 cycle.
  - In the same cycle the counter restarts at 0, or at 1 if the sof pixel itself has w ≠ 0.
  - The first sof after reset also latches, reporting 0.
- Undefined: stat_cnt and stat_vld are tied to 0 and no counter logic is built.

Decomposition:
- Shared package: DW_IN/DW_DEC defaults, MTMP_ONE = 2^DW_DEC, MTMP_LAT default. The mtmp generator and this block share these so latency stays consistent.
- One natural sub-module: pix_dly_line, a parameterised width×depth shift register with async active-low reset. It is instantiated once for the {sof, vld, orig, corr} bundle.

Test Plan (defaults):
- orig=1000, corr=600, mtmp=128 (0.5) → pix_out=800 at exactly t+8, out_vld high for 1 cycle.
- mtmp=0 → pix_out=orig. mtmp=256 → pix_out=corr. mtmp=300 → clamped, pix_out=corr, for orig=1023, corr=17.
- Rounding: orig=0, corr=1, mtmp=128 → 128+128=256 → pix_out=1. mtmp=127 → 255 → pix_out=0.
- Randomised in_vld gaps at 30% duty versus a reference model: output order, count and alignment match, and no output appears for an invalid slot.
- rst_n asserted mid-frame with 5 pixels in flight → outputs clear immediately, and no stale out_vld appears after release.
- MTMP_STAT_EN:
  - Frame of 100 pixels with 37 having w≠0, then in_sof → stat_cnt=37 and stat_vld 1-cycle pulse with out_sof.
  - Forced counter at max → holds at saturation.

Source files
------------

// File: rtl/mtmp_blend_pkg.sv
// Shared constants for the mtmp weight generator and the mtmp blend stage.
// Both blocks take their widths and latency from here so they stay in step.
package mtmp_blend_pkg;

    localparam int DW_IN_DEF    = 10;
    localparam int DW_DEC_DEF   = 8;
    localparam int MTMP_ONE     = 1 << DW_DEC_DEF;
    localparam int MTMP_LAT_DEF = 6;
    localparam int STAT_W_DEF   = 22;

    // Width of one weighted product: pixel times a Q1.DW_DEC weight.
    function automatic int prod_width(input int dw_in, input int dw_dec);
        return dw_in + dw_dec + 1;
    endfunction

endpackage

// File: rtl/mtmp_blend_if.sv
// Pixel stream bundle of the mtmp blend stage: original/corrected pixels and
// weight in, blended pixel out. master drives the inputs, slave is the blender.
interface mtmp_blend_if
    import mtmp_blend_pkg::*;
#(
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_DEC = DW_DEC_DEF
);

    logic              in_vld;
    logic              in_sof;
    logic [DW_IN-1:0]  pix_orig;
    logic [DW_IN-1:0]  pix_corr;
    logic [DW_DEC:0]   mtmp;
    logic              out_vld;
    logic              out_sof;
    logic [DW_IN-1:0]  pix_out;

    modport master (
        output in_vld, in_sof, pix_orig, pix_corr, mtmp,
        input  out_vld, out_sof, pix_out
    );

    modport slave (
        input  in_vld, in_sof, pix_orig, pix_corr, mtmp,
        output out_vld, out_sof, pix_out
    );

endinterface

// File: rtl/mtmp_blend_pix_dly_line.sv
// pix_dly_line: free-running WIDTH x DEPTH shift register, cleared by the
// asynchronous active-low reset. Shifts every cycle; there is no enable.
module pix_dly_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mtmp_blend.sv
// mtmp_blend: aligns orig/corr pixels to the mtmp weight and blends them.
// Define MTMP_STAT_EN to build the per-frame corrected-pixel counter.
module mtmp_blend
    import mtmp_blend_pkg::*;
#(
    parameter int DW_IN    = DW_IN_DEF,
    parameter int DW_DEC   = DW_DEC_DEF,
    parameter int MTMP_LAT = MTMP_LAT_DEF,
    parameter int STAT_W   = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mtmp_blend_if.slave       bus,
    output logic [STAT_W-1:0] stat_cnt,
    output logic              stat_vld
);

    localparam int PW = prod_width(DW_IN, DW_DEC);
    localparam int LW = 2 * DW_IN + 2;
    localparam logic [DW_DEC:0] W_ONE = {1'b1, {DW_DEC{1'b0}}};
    localparam logic [PW:0]     ROUND = (PW + 1)'(1) << (DW_DEC - 1);

    logic [LW-1:0]     dly_in;
    logic [LW-1:0]     dly_out;
    logic              vld_dly;
    logic              sof_dly;
    logic [DW_IN-1:0]  orig_dly;
    logic [DW_IN-1:0]  corr_dly;

    // sof is qualified here so a stray sof on an empty slot never propagates.
    assign dly_in = {bus.in_sof & bus.in_vld, bus.in_vld, bus.pix_orig, bus.pix_corr};
    assign {sof_dly, vld_dly, orig_dly, corr_dly} = dly_out;

    pix_dly_line #(
        .WIDTH (LW),
        .DEPTH (MTMP_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dly_in),
        .dout  (dly_out)
    );

    logic [DW_DEC:0]   w;
    logic [PW-1:0]     pa_q, pa_d, pb_q, pb_d;
    logic              vld_b1_q, vld_b1_d, sof_b1_q, sof_b1_d;
    logic [PW:0]       sum;
    logic              sum_unused;
    logic [DW_IN-1:0]  pix_out_q, pix_out_d;
    logic              out_vld_q, out_vld_d, out_sof_q, out_sof_d;

    always_comb begin
        w         = (bus.mtmp > W_ONE) ? W_ONE : bus.mtmp;
        pa_d      = PW'(w) * PW'(corr_dly);
        pb_d      = PW'(W_ONE - w) * PW'(orig_dly);
        vld_b1_d  = vld_dly;
        sof_b1_d  = sof_dly;
        // Weights sum to one, so the rounded result always fits DW_IN bits.
        sum       = {1'b0, pa_q} + {1'b0, pb_q} + ROUND;
        pix_out_d = sum[DW_DEC +: DW_IN];
        out_vld_d = vld_b1_q;
        out_sof_d = sof_b1_q;
    end

    assign sum_unused = ^{sum[DW_DEC-1:0], sum[PW:DW_DEC+DW_IN]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_q      <= '0;
            pb_q      <= '0;
            vld_b1_q  <= 1'b0;
            sof_b1_q  <= 1'b0;
            pix_out_q <= '0;
            out_vld_q <= 1'b0;
            out_sof_q <= 1'b0;
        end else begin
            pa_q      <= pa_d;
            pb_q      <= pb_d;
            vld_b1_q  <= vld_b1_d;
            sof_b1_q  <= sof_b1_d;
            pix_out_q <= pix_out_d;
            out_vld_q <= out_vld_d;
            out_sof_q <= out_sof_d;
        end
    end

    assign bus.out_vld = out_vld_q;
    assign bus.out_sof = out_sof_q;
    assign bus.pix_out = pix_out_q;

`ifdef MTMP_STAT_EN
    logic              nz_b1_q, nz_b1_d;
    logic              seen_sof_q, seen_sof_d;
    logic              stat_vld_q, stat_vld_d;
    logic [STAT_W-1:0] cnt_q, cnt_d, stat_cnt_q, stat_cnt_d;

    // Counting happens as a pixel enters B2, so stat_vld lines up with out_sof.
    always_comb begin
        nz_b1_d    = (w != '0);
        cnt_d      = cnt_q;
        stat_cnt_d = stat_cnt_q;
        stat_vld_d = 1'b0;
        seen_sof_d = seen_sof_q;
        if (vld_b1_q && sof_b1_q) begin
            stat_cnt_d = seen_sof_q ? cnt_q : '0;
            stat_vld_d = 1'b1;
            seen_sof_d = 1'b1;
            cnt_d      = nz_b1_q ? STAT_W'(1) : '0;
        end else if (vld_b1_q && nz_b1_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_b1_q    <= 1'b0;
            seen_sof_q <= 1'b0;
            stat_vld_q <= 1'b0;
            cnt_q      <= '0;
            stat_cnt_q <= '0;
        end else begin
            nz_b1_q    <= nz_b1_d;
            seen_sof_q <= seen_sof_d;
            stat_vld_q <= stat_vld_d;
            cnt_q      <= cnt_d;
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_cnt = stat_cnt_q;
    assign stat_vld = stat_vld_q;
`else
    assign stat_cnt = '0;
    assign stat_vld = 1'b0;
`endif

endmodule

// File: tb/tb_mtmp_blend.sv
// Directed + gapped-stream bench for mtmp_blend: a slot-indexed reference model
// predicts every output cycle; literal expectations pin the model itself.
`timescale 1ns/1ps
module tb_mtmp_blend;
    import mtmp_blend_pkg::*;

    localparam int DW    = DW_IN_DEF;
    localparam int MW    = DW_DEC_DEF + 1;
    localparam int LAT   = MTMP_LAT_DEF;
    localparam int PIPE  = LAT + 2;
    localparam int NSLOT = 520;
    localparam int R0    = 405;
    localparam int R1    = 408;
    localparam int SAT_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [STAT_W_DEF-1:0] stat_cnt;
    logic                  stat_vld;

    always #5 clk = ~clk;

    mtmp_blend_if #(.DW_IN(DW_IN_DEF), .DW_DEC(DW_DEC_DEF)) bus ();

    mtmp_blend #(
        .DW_IN    (DW_IN_DEF),
        .DW_DEC   (DW_DEC_DEF),
        .MTMP_LAT (MTMP_LAT_DEF),
        .STAT_W   (STAT_W_DEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .stat_cnt (stat_cnt),
        .stat_vld (stat_vld)
    );

`ifdef MTMP_STAT_EN
    logic [SAT_W-1:0] stat_cnt2;
    logic             stat_vld2;
    mtmp_blend_if #(.DW_IN(DW_IN_DEF), .DW_DEC(DW_DEC_DEF)) bus2 ();
    assign bus2.in_vld   = bus.in_vld;
    assign bus2.in_sof   = bus.in_sof;
    assign bus2.pix_orig = bus.pix_orig;
    assign bus2.pix_corr = bus.pix_corr;
    assign bus2.mtmp     = bus.mtmp;

    mtmp_blend #(
        .DW_IN    (DW_IN_DEF),
        .DW_DEC   (DW_DEC_DEF),
        .MTMP_LAT (MTMP_LAT_DEF),
        .STAT_W   (SAT_W)
    ) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus2),
        .stat_cnt (stat_cnt2),
        .stat_vld (stat_vld2)
    );
`endif

    // Stimulus tables, one entry per input slot (cycle).
    int s_vld  [NSLOT];
    int s_sof  [NSLOT];
    int s_orig [NSLOT];
    int s_corr [NSLOT];
    int s_m    [NSLOT];
    bit disc   [NSLOT];

    int n_chk  = 0;
    int n_fail = 0;
    int cur    = 0;
    bit running = 1'b0;

    // Output cycle -> required pix_out (-1: out_vld must be low).
    int lit_cyc [8] = '{17, 18, 19, 28, 30, 32, 34, 36};
    int lit_pix [8] = '{-1, 800, -1, 1000, 17, 17, 1, 0};

    task automatic chk(input string name, input longint act, input longint exp, input int cyc);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int wclamp(input int m);
        return (m > MTMP_ONE) ? MTMP_ONE : m;
    endfunction

    function automatic int blend(input int o, input int c, input int m);
        int w;
        w = wclamp(m);
        return (w * c + (MTMP_ONE - w) * o + MTMP_ONE / 2) / MTMP_ONE;
    endfunction

    // Reference comparison, sampled on the falling edge.
    initial begin : compare
        int k;
        bit ev, es, nz;
        int m_cnt, m_seen, m_stat, q_cnt, q_seen, q_stat;
        m_cnt = 0; m_seen = 0; m_stat = 0;
        q_cnt = 0; q_seen = 0; q_stat = 0;
        forever begin
            @(negedge clk);
            if (running) begin
                if (!rst_n) begin
                    chk("rst_out_vld", bus.out_vld, 0, cur);
                    chk("rst_out_sof", bus.out_sof, 0, cur);
                    chk("rst_pix_out", bus.pix_out, 0, cur);
                    chk("rst_stat_cnt", stat_cnt, 0, cur);
                    chk("rst_stat_vld", stat_vld, 0, cur);
                    m_cnt = 0; m_seen = 0; m_stat = 0;
                    q_cnt = 0; q_seen = 0; q_stat = 0;
                end else begin
                    k  = cur - PIPE;
                    ev = (k >= 0) && (s_vld[k] != 0) && !disc[k];
                    es = ev && (s_sof[k] != 0);
                    chk("out_vld", bus.out_vld, ev, cur);
                    chk("out_sof", bus.out_sof, es, cur);
                    if (ev) begin
                        chk("pix_out", bus.pix_out, blend(s_orig[k], s_corr[k], s_m[k]), cur);
                    end
`ifdef MTMP_STAT_EN
                    if (ev) begin
                        nz = (wclamp(s_m[k]) != 0);
                        if (es) begin
                            m_stat = m_seen ? m_cnt : 0;
                            q_stat = q_seen ? q_cnt : 0;
                            m_seen = 1; q_seen = 1;
                            m_cnt = nz; q_cnt = nz;
                        end else if (nz) begin
                            if (m_cnt < (1 << STAT_W_DEF) - 1) m_cnt++;
                            if (q_cnt < (1 << SAT_W) - 1) q_cnt++;
                        end
                    end
                    chk("stat_cnt", stat_cnt, m_stat, cur);
                    chk("stat_vld", stat_vld, es, cur);
                    chk("sat_stat_cnt", stat_cnt2, q_stat, cur);
                    chk("sat_stat_vld", stat_vld2, es, cur);
                    if (cur == 140 + PIPE) begin
                        chk("lit_stat_37", stat_cnt, 37, cur);
                        chk("lit_stat_sat", stat_cnt2, 7, cur);
                    end
`else
                    chk("stat_cnt_tied", stat_cnt, 0, cur);
                    chk("stat_vld_tied", stat_vld, 0, cur);
`endif
                    for (int i = 0; i < 8; i++) begin
                        if (cur == lit_cyc[i]) begin
                            if (lit_pix[i] < 0) begin
                                chk("lit_gap_vld", bus.out_vld, 0, cur);
                            end else begin
                                chk("lit_vld", bus.out_vld, 1, cur);
                                chk("lit_pix", bus.pix_out, lit_pix[i], cur);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic rand_slot(input int k);
        s_vld[k] = ($urandom_range(0, 9) < 3) ? 1 : 0;
        s_sof[k] = ($urandom_range(0, 19) == 0) ? 1 : 0;
        s_m[k]   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 300));
    endtask

    task automatic set_slot(input int k, input int sof, input int o, input int c, input int m);
        s_vld[k] = 1; s_sof[k] = sof; s_orig[k] = o; s_corr[k] = c; s_m[k] = m;
    endtask

    initial begin : drive
        for (int k = 0; k < NSLOT; k++) begin
            s_vld[k]  = 0;
            s_sof[k]  = 0;
            s_orig[k] = int'($urandom_range(0, 1023));
            s_corr[k] = int'($urandom_range(0, 1023));
            s_m[k]    = int'($urandom_range(0, 300));
            disc[k]   = (k >= R0 - PIPE) && (k < R1);
        end
        set_slot(10, 1, 1000, 600, 128);
        set_slot(20, 0, 1000, 600, 0);
        set_slot(22, 0, 1023, 17, 256);
        set_slot(24, 0, 1023, 17, 300);
        set_slot(26, 0, 0, 1, 128);
        set_slot(28, 0, 0, 1, 127);
        s_sof[30] = 1;
        for (int i = 0; i < 100; i++) begin
            s_vld[40 + i] = 1;
            s_sof[40 + i] = (i == 0) ? 1 : 0;
            s_m[40 + i]   = (((i * 37) % 100) < 37) ? int'($urandom_range(1, 300)) : 0;
        end
        for (int k = 140; k < 150; k++) begin
            s_vld[k] = 1;
            s_sof[k] = (k == 140) ? 1 : 0;
        end
        for (int k = 150; k < 400; k++) rand_slot(k);
        for (int k = 400; k < 420; k++) begin
            s_vld[k] = 1;
            s_sof[k] = (k == 400 || k == 410) ? 1 : 0;
        end
        for (int k = 420; k < 480; k++) rand_slot(k);

        bus.in_vld = 1'b0; bus.in_sof = 1'b0;
        bus.pix_orig = '0; bus.pix_corr = '0; bus.mtmp = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        running = 1'b1;
        for (int k = 0; k < NSLOT; k++) begin
            cur          = k;
            rst_n        = !((k >= R0) && (k < R1));
            bus.in_vld   = s_vld[k][0];
            bus.in_sof   = s_sof[k][0];
            bus.pix_orig = DW'(s_orig[k]);
            bus.pix_corr = DW'(s_corr[k]);
            bus.mtmp     = (k >= LAT) ? MW'(s_m[k - LAT]) : '0;
            $display("slot %0d vld=%0d sof=%0d orig=%0d corr=%0d mtmp=%0d out_vld=%0d pix_out=%0d",
                     k, s_vld[k], s_sof[k], s_orig[k], s_corr[k], bus.mtmp, bus.out_vld, bus.pix_out);
            @(posedge clk);
            #1;
        end
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
